// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RV32I fetch stage: PC, combinational IMEM capture, fetch FIFO to decode
// Optional statistics counters are enabled with `define FETCH_STAT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] Instr_Addr,
    input  logic [31:0] Instr_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
`ifdef FETCH_STAT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

    state_t          state, state_next;
    logic [31:0]     pc;
    logic [31:0]     last_pc;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, count_next;
    logic [31:0]     fifo_pc    [FIFO_DEPTH];
    logic [31:0]     fifo_instr [FIFO_DEPTH];
    logic            full;
    logic            pop, push;

    assign Instr_Addr = pc;
    assign pop  = if_valid & if_ready;
    // A full buffer still fetches when the head leaves in the same cycle.
    assign push = !redirect & (!full | pop);

    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_next;
    end

    always_comb begin
        count_next = count;
        if (redirect)
            count_next = '0;
        else if (push && !pop)
            count_next = count + CW'(1);
        else if (!push && pop)
            count_next = count - CW'(1);

        if (count_next == '0)          state_next = EMPTY;
        else if (count_next == DEPTH_C) state_next = FULL;
        else                            state_next = PARTIAL;
    end

    always_comb begin
        if_valid = (state != EMPTY);
        full     = (state == FULL);
        if_instr = if_valid ? fifo_instr[rd_ptr] : NOP;
        if_pc    = if_valid ? fifo_pc[rd_ptr]    : last_pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            last_pc <= '0;
        end else begin
            count <= count_next;
            if (pop)
                last_pc <= fifo_pc[rd_ptr];
            if (redirect) begin
                pc     <= {redirect_pc[31:2], 2'b00};
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    fifo_pc[wr_ptr]    <= pc;
                    fifo_instr[wr_ptr] <= Instr_rdata;
                    wr_ptr             <= wr_ptr + PW'(1);
                    pc                 <= pc + 32'd4;
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

`ifdef FETCH_STAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (push && fetch_cnt != '1)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (full && !pop && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
            if (redirect && flush_cnt != '1)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr_Addr;
    logic [31:0] Instr_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef FETCH_STAT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .Instr_Addr  (Instr_Addr),
        .Instr_rdata (Instr_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc)
`ifdef FETCH_STAT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0020_A023;
            32'h4:   return 32'h0020_8223;
            32'h8:   return 32'h0020_9423;
            default: return 32'hA000_0000 ^ a;
        endcase
    endfunction

    assign Instr_rdata = imem(Instr_Addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        if_ready    = rdy;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        // Streaming fetch with decode always ready
        do_reset(1'b1);
        check("rst_valid", {31'b0, if_valid}, 32'd0);
        check("rst_instr", if_instr, 32'h0000_0013);
        check("rst_pc",    if_pc, 32'h0);
        check("rst_addr",  Instr_Addr, 32'h0);
        step();
        check("s1_valid", {31'b0, if_valid}, 32'd1);
        check("s1_pc",    if_pc, 32'h0);
        check("s1_instr", if_instr, 32'h0020_A023);
        step();
        check("s2_pc",    if_pc, 32'h4);
        check("s2_instr", if_instr, 32'h0020_8223);
        step();
        check("s3_pc",    if_pc, 32'h8);
        check("s3_instr", if_instr, 32'h0020_9423);

        // Decode stalls five cycles, then drains
        do_reset(1'b0);
        step();
        check("st1_addr", Instr_Addr, 32'h4);
        step();
        check("st2_addr", Instr_Addr, 32'h8);
        check("st2_head", if_pc, 32'h0);
        step();
        step();
        step();
        check("st5_addr",  Instr_Addr, 32'h8);
        check("st5_valid", {31'b0, if_valid}, 32'd1);
        check("st5_head",  if_pc, 32'h0);
        check("st5_instr", if_instr, 32'h0020_A023);
`ifdef FETCH_STAT_EN
        check("st_stall", stall_cnt, 32'd3);
        check("st_fetch", fetch_cnt, 32'd2);
        check("st_flush", {16'b0, flush_cnt}, 32'd0);
`endif
        if_ready = 1'b1;
        step();
        check("dr1_head", if_pc, 32'h4);
        check("dr1_addr", Instr_Addr, 32'hC);
        step();
        check("dr2_head",  if_pc, 32'h8);
        check("dr2_instr", if_instr, 32'h0020_9423);
        step();
        check("dr3_head",  if_pc, 32'hC);
        check("dr3_instr", if_instr, 32'hA000_000C);

        // Redirect in cycle 3 to a misaligned target
        do_reset(1'b1);
        step();
        step();
        step();
        check("rd3_head", if_pc, 32'h8);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0042;
        step();
        redirect = 1'b0;
        check("rd4_valid", {31'b0, if_valid}, 32'd0);
        check("rd4_addr",  Instr_Addr, 32'h40);
`ifdef FETCH_STAT_EN
        check("rd_flush", {16'b0, flush_cnt}, 32'd1);
`endif
        step();
        check("rd5_valid", {31'b0, if_valid}, 32'd1);
        check("rd5_pc",    if_pc, 32'h40);
        check("rd5_instr", if_instr, 32'hA000_0040);
        step();
        check("rd6_pc", if_pc, 32'h44);

        // PC wrap from the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect = 1'b0;
        check("wr_valid", {31'b0, if_valid}, 32'd0);
        check("wr_addr0", Instr_Addr, 32'hFFFF_FFFC);
        step();
        check("wr_addr1", Instr_Addr, 32'h0);
        check("wr_head1", if_pc, 32'hFFFF_FFFC);
        check("wr_inst1", if_instr, 32'h5FFF_FFFC);
        step();
        check("wr_head2", if_pc, 32'h0);
        check("wr_inst2", if_instr, 32'h0020_A023);

        // Reset takes priority over a simultaneous redirect
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        reset    = 1'b0;
        redirect = 1'b0;
        check("rr_addr",  Instr_Addr, 32'h0);
        check("rr_valid", {31'b0, if_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
